nonce_dispatcher: RTL



---
 rtl/nonce_dispatcher.sv | 113 +++++++++++
 1 files changed

// File: rtl/nonce_dispatcher.sv
// Nonce stream generator: walks [start, end] by STRIDE over a valid/ready link.
// IDLE -> RUN -> DONE sequencing with a one-cycle done pulse and issue counter.
module nonce_dispatcher #(
  parameter int unsigned     NONCE_W = 32,
  parameter longint unsigned STRIDE  = 1,
  parameter int unsigned     CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  output logic               nonce_valid,
  input  logic               nonce_ready,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   issued_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [NONCE_W:0] STEP = (NONCE_W+1)'(STRIDE);

  state_e             state_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] nonce_d;
  logic [NONCE_W-1:0] end_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               xfer;
  logic               last;
  logic [NONCE_W:0]   gap;

  assign xfer    = valid_q & nonce_ready;
  // Extra bit keeps the remaining-distance test free of wrap at the top.
  assign gap     = {1'b0, end_q} - {1'b0, nonce_q};
  assign last    = gap < STEP;
  assign nonce_d = nonce_q + STEP[NONCE_W-1:0];
  assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      nonce_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            end_q   <= nonce_end;
            nonce_q <= nonce_start;
            cnt_q   <= '0;
            if (nonce_start <= nonce_end) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) cnt_q <= cnt_d;
          if (abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (xfer) begin
            if (last) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              nonce_q <= nonce_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign nonce_valid  = valid_q;
  assign nonce        = nonce_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign issued_count = cnt_q;

endmodule
